// File: rtl/uart_price_frame_ctrl.sv
// uart_price_frame_ctrl
// Receive-side sequencer between the UART RX FIFO and the trading core.
// Pops bytes under a one-pop-per-two-cycles handshake, hunts for HEADER,
// assembles a big-endian 16-bit price and hands it over as a one-cycle
// price_valid pulse. A stalled frame is aborted after TIMEOUT_CYCLES idle
// cycles.
//
// Build option: define PRICE_FRAME_CKSUM_EN for the 4-byte frame
// (HEADER, hi, lo, hi^lo). Without it the frame is 3 bytes (HEADER, hi, lo),
// there is no checksum stage and frame_err only reports timeouts.
module uart_price_frame_ctrl #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rx_empty,
  input  logic [7:0]           rx_data,
  output logic                 rd_uart,
  output logic [15:0]          price_out,
  output logic                 price_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          frame_count,
  output logic                 busy
);

  // The idle counter only has to count up to TIMEOUT_CYCLES-1; the abort
  // fires on the cycle that would take it to TIMEOUT_CYCLES.
  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    HUNT,
    HI,
    LO,
    CK,
    EMIT
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             hiByte_q, hiByte_d;
`ifdef PRICE_FRAME_CKSUM_EN
  logic [7:0]             loByte_q, loByte_d;
`endif
  logic [TW-1:0]          timeoutCnt_q, timeoutCnt_d;
  logic [15:0]            priceOut_q, priceOut_d;
  logic                   priceValid_q, priceValid_d;
  logic                   frameErr_q, frameErr_d;
  logic [ERR_CNT_W-1:0]   errCount_q, errCount_d;
  logic [15:0]            frameCount_q, frameCount_d;
  logic                   cooldown_q;

  logic                   pop;
  logic                   inFrame;
  logic                   accept;
  logic                   abort;
  logic [15:0]            acceptPrice;

  // A pop is allowed only one cycle after the previous one so the FIFO
  // empty flag has time to reflect the consumed byte.
  assign pop     = enable & ~rx_empty & ~cooldown_q & ~rst;
  assign rd_uart = pop;
  assign inFrame = (state_q == HI) || (state_q == LO) || (state_q == CK);

  // Next-state logic: byte sequencing, idle timeout, and the accept/abort
  // bookkeeping that both end a frame and return to HUNT.
  always_comb begin
    state_d      = state_q;
    hiByte_d     = hiByte_q;
`ifdef PRICE_FRAME_CKSUM_EN
    loByte_d     = loByte_q;
`endif
    timeoutCnt_d = timeoutCnt_q;
    priceOut_d   = priceOut_q;
    priceValid_d = 1'b0;
    frameErr_d   = 1'b0;
    errCount_d   = errCount_q;
    frameCount_d = frameCount_q;
    accept       = 1'b0;
    abort        = 1'b0;
    acceptPrice  = {hiByte_q, rx_data};

    case (state_q)
      HUNT: begin
        timeoutCnt_d = '0;
        if (pop && (rx_data == HEADER)) begin
          state_d = HI;
        end
      end
      HI: begin
        if (pop) begin
          hiByte_d = rx_data;
          state_d  = LO;
        end
      end
      LO: begin
        if (pop) begin
`ifdef PRICE_FRAME_CKSUM_EN
          loByte_d = rx_data;
          state_d  = CK;
`else
          accept      = 1'b1;
          acceptPrice = {hiByte_q, rx_data};
`endif
        end
      end
`ifdef PRICE_FRAME_CKSUM_EN
      CK: begin
        if (pop) begin
          if (rx_data == (hiByte_q ^ loByte_q)) begin
            accept      = 1'b1;
            acceptPrice = {hiByte_q, loByte_q};
          end else begin
            abort = 1'b1;
          end
        end
      end
`endif
      EMIT: begin
        timeoutCnt_d = '0;
        state_d      = HUNT;
      end
      default: begin
        timeoutCnt_d = '0;
        state_d      = HUNT;
      end
    endcase

    // A pop on the expiry cycle wins: the byte is processed, no abort.
    if (inFrame) begin
      if (pop) begin
        timeoutCnt_d = '0;
      end else if (enable) begin
        if (timeoutCnt_q == TMO_LAST) begin
          abort = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + TW'(1);
        end
      end
    end

    if (accept) begin
      state_d      = EMIT;
      priceOut_d   = acceptPrice;
      priceValid_d = 1'b1;
      frameCount_d = frameCount_q + 16'd1;
      timeoutCnt_d = '0;
    end

    if (abort) begin
      state_d      = HUNT;
      timeoutCnt_d = '0;
      frameErr_d   = 1'b1;
      if (errCount_q != '1) begin
        errCount_d = errCount_q + ERR_CNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      hiByte_q     <= '0;
`ifdef PRICE_FRAME_CKSUM_EN
      loByte_q     <= '0;
`endif
      timeoutCnt_q <= '0;
      priceOut_q   <= '0;
      priceValid_q <= 1'b0;
      frameErr_q   <= 1'b0;
      errCount_q   <= '0;
      frameCount_q <= '0;
      cooldown_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hiByte_q     <= hiByte_d;
`ifdef PRICE_FRAME_CKSUM_EN
      loByte_q     <= loByte_d;
`endif
      timeoutCnt_q <= timeoutCnt_d;
      priceOut_q   <= priceOut_d;
      priceValid_q <= priceValid_d;
      frameErr_q   <= frameErr_d;
      errCount_q   <= errCount_d;
      frameCount_q <= frameCount_d;
      cooldown_q   <= pop;
    end
  end

  assign price_out   = priceOut_q;
  assign price_valid = priceValid_q;
  assign frame_err   = frameErr_q;
  assign err_count   = errCount_q;
  assign frame_count = frameCount_q;
  assign busy        = (state_q != HUNT);

endmodule
